// File: rtl/aes_ctrl_pkg.sv
// Shared state type, widths and AES-256 round primitives for the AES core arbiter.
// Bytes of a 128-bit state are numbered from the MSB, column-major, as in FIPS-197.
package aes_ctrl_pkg;

   localparam int AES_BLOCK_W    = 128;
   localparam int AES_KEY_W      = 256;
   localparam int AES_NUM_ROUNDS = 14;
   localparam int AES_NUM_WORDS  = 4 * (AES_NUM_ROUNDS + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] AES_SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      int idx;
      idx = 2047 - 8 * int'(b);
      return AES_SBOX[idx -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [AES_BLOCK_W-1:0] sub_bytes(input logic [AES_BLOCK_W-1:0] s);
      logic [AES_BLOCK_W-1:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) begin
         o[AES_BLOCK_W-1-8*i -: 8] = sbox(s[AES_BLOCK_W-1-8*i -: 8]);
      end
      return o;
   endfunction

   // Row r of column c takes the byte from column (c + r) mod 4.
   function automatic logic [AES_BLOCK_W-1:0] shift_rows(input logic [AES_BLOCK_W-1:0] s);
      logic [AES_BLOCK_W-1:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[AES_BLOCK_W-1-8*(4*c+r) -: 8] = s[AES_BLOCK_W-1-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [AES_BLOCK_W-1:0] mix_columns(input logic [AES_BLOCK_W-1:0] s);
      logic [AES_BLOCK_W-1:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         o[AES_BLOCK_W-1-32*c -: 32] = mix_column(s[AES_BLOCK_W-1-32*c -: 32]);
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_encryption.sv
// Purely combinational AES-256 encryption: full key schedule plus 14 unrolled rounds.
// Callers hold operands stable long enough for this cone to settle.
module aes_encryption
   import aes_ctrl_pkg::*;
(
   input  logic [AES_BLOCK_W-1:0] plaintext,
   input  logic [AES_KEY_W-1:0]   initial_key,
   output logic [AES_BLOCK_W-1:0] ciphertext
);

   logic [31:0] rkWords [AES_NUM_WORDS];

   // Key schedule: every eighth word rotates and gets Rcon, the middle word of each group is only substituted.
   always_comb begin
      logic [31:0] w [AES_NUM_WORDS];
      logic [31:0] temp;
      logic [7:0]  rcon;
      temp = '0;
      rcon = 8'h01;
      for (int i = 0; i < AES_NUM_WORDS; i++) begin
         w[i] = '0;
      end
      for (int i = 0; i < 8; i++) begin
         w[i] = initial_key[AES_KEY_W-1-32*i -: 32];
      end
      for (int i = 8; i < AES_NUM_WORDS; i++) begin
         temp = w[i-1];
         if (i % 8 == 0) begin
            temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h000000};
            rcon = xtime(rcon);
         end else if (i % 8 == 4) begin
            temp = sub_word(temp);
         end
         w[i] = w[i-8] ^ temp;
      end
      rkWords = w;
   end

   // The last round skips MixColumns.
   always_comb begin
      logic [AES_BLOCK_W-1:0] s;
      s = plaintext ^ {rkWords[0], rkWords[1], rkWords[2], rkWords[3]};
      for (int r = 1; r <= AES_NUM_ROUNDS; r++) begin
         s = shift_rows(sub_bytes(s));
         if (r != AES_NUM_ROUNDS) begin
            s = mix_columns(s);
         end
         s = s ^ {rkWords[4*r], rkWords[4*r+1], rkWords[4*r+2], rkWords[4*r+3]};
      end
      ciphertext = s;
   end

endmodule

// File: rtl/aes_core_arbiter.sv
// Two-requester round-robin front end for one shared combinational AES-256 core.
// One transaction at a time: accept, let the core settle, capture, hand the result out.
module aes_core_arbiter
   import aes_ctrl_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4
)(
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [1:0]               req_v_i,
   output logic [1:0]               req_ready_o,
   input  logic [2*AES_BLOCK_W-1:0] req_plaintext_i,
   input  logic [2*AES_KEY_W-1:0]   req_key_i,
   output logic                     resp_v_o,
   input  logic                     resp_ready_i,
   output logic                     resp_id_o,
   output logic [AES_BLOCK_W-1:0]   resp_ciphertext_o,
   output logic                     busy_o
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

   arb_state_e             state_q;
   logic                   prio_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [AES_BLOCK_W-1:0] pt_q;
   logic [AES_KEY_W-1:0]   key_q;
   logic                   id_q;
   logic [AES_BLOCK_W-1:0] result_q;
   logic                   respV_q;
   logic                   busy_q;

   logic                   acceptV;
   logic                   acceptId;
   logic [AES_BLOCK_W-1:0] selPlaintext;
   logic [AES_KEY_W-1:0]   selKey;
   logic [AES_BLOCK_W-1:0] coreCiphertext;

   // Ready is masked by reset too, since the async reset leaves state_q at IDLE while asserted.
   always_comb begin
      req_ready_o = 2'b00;
      if (state_q == IDLE && !reset_i) begin
         req_ready_o[0] = req_v_i[0] && (!prio_q || !req_v_i[1]);
         req_ready_o[1] = req_v_i[1] && (prio_q || !req_v_i[0]);
      end
   end

   assign acceptV      = |req_ready_o;
   assign acceptId     = req_ready_o[1];
   assign selPlaintext = acceptId ? req_plaintext_i[2*AES_BLOCK_W-1 -: AES_BLOCK_W]
                                  : req_plaintext_i[AES_BLOCK_W-1:0];
   assign selKey       = acceptId ? req_key_i[2*AES_KEY_W-1 -: AES_KEY_W]
                                  : req_key_i[AES_KEY_W-1:0];

   aes_encryption u_aes (
      .plaintext   (pt_q),
      .initial_key (key_q),
      .ciphertext  (coreCiphertext)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         prio_q   <= 1'b0;
         cnt_q    <= '0;
         pt_q     <= '0;
         key_q    <= '0;
         id_q     <= 1'b0;
         result_q <= '0;
         respV_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (acceptV) begin
                  pt_q    <= selPlaintext;
                  key_q   <= selKey;
                  id_q    <= acceptId;
                  prio_q  <= ~acceptId;
                  cnt_q   <= CNT_W'(SETTLE_CYCLES - 1);
                  busy_q  <= 1'b1;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == '0) begin
                  result_q <= coreCiphertext;
                  respV_q  <= 1'b1;
                  state_q  <= RESP;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            RESP: begin
               if (resp_ready_i) begin
                  respV_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               respV_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign resp_v_o          = respV_q;
   assign resp_id_o         = id_q;
   assign resp_ciphertext_o = result_q;
   assign busy_o            = busy_q;

   // Design invariants: a single grant per cycle, and a stalled response never changes.
   a_one_grant : assert property (@(posedge clk_i) disable iff (reset_i)
      !(req_ready_o[0] && req_ready_o[1]));

   a_resp_hold : assert property (@(posedge clk_i) disable iff (reset_i)
      (resp_v_o && !resp_ready_i) |=>
         (resp_v_o && $stable(resp_ciphertext_o) && $stable(resp_id_o)));

endmodule

// File: doc/aes_core_arbiter.md
AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, number of cycles operands are held stable on the shared aes_encryption core before ciphertext capture; legal range 1..255.
REQ-002 SHALL have port clk_i, input, 1, the single clock.
REQ-003 SHALL have port reset_i, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port req_v_i, input, 2, per-requester request valid; bit k belongs to requester k.
REQ-005 SHALL have port req_ready_o, output, 2, per-requester request accept.
REQ-006 SHALL have port req_plaintext_i, input, 256, two packed 128-bit plaintexts; requester k uses bits [128k+127:128k].
REQ-007 SHALL have port req_key_i, input, 512, two packed 256-bit keys; requester k uses bits [256k+255:256k].
REQ-008 SHALL have port resp_v_o, output, 1, response valid.
REQ-009 SHALL have port resp_ready_i, input, 1, response consumer ready.
REQ-010 SHALL have port resp_id_o, output, 1, index of the requester that owns the response.
REQ-011 SHALL have port resp_ciphertext_o, output, 128, AES-256 ciphertext.
REQ-012 SHALL have port busy_o, output, 1, high whenever the state is not IDLE.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-014 In IDLE, req_ready_o[k] SHALL be 1 iff req_v_i[k]=1 and either prio=k or req_v_i[1-k]=0; in WAIT and RESP, req_ready_o SHALL be 2'b00.
REQ-015 A request SHALL be accepted on a cycle where req_v_i[k] and req_ready_o[k] are both 1; at most one acceptance SHALL occur per cycle.
REQ-016 On acceptance, the block SHALL register the requester's plaintext, key and id; set prio to 1-k; load the settle counter with SETTLE_CYCLES-1; and enter WAIT.
REQ-017 The registered plaintext and key SHALL drive the instantiated aes_encryption core directly, with no other logic on that path.
REQ-018 WAIT SHALL last exactly SETTLE_CYCLES cycles; the counter SHALL decrement once per cycle.
REQ-019 In the WAIT cycle where the counter equals 0, the block SHALL capture the core ciphertext into the result register and enter RESP.
REQ-020 Latency: for an acceptance at cycle N, resp_v_o SHALL first be 1 at cycle N+SETTLE_CYCLES+1.
REQ-021 In RESP, resp_v_o SHALL be 1, and resp_id_o and resp_ciphertext_o SHALL be held stable until resp_v_o and resp_ready_i are both 1.
REQ-022 On the response handshake, the block SHALL return to IDLE; a new acceptance SHALL be possible on the next cycle.
REQ-023 Request inputs SHALL be ignored outside IDLE; the registered operands SHALL not change in WAIT or RESP.
REQ-024 A requester whose req_v_i drops before acceptance SHALL not be served, and no state SHALL change as a result.

Reset
REQ-025 While reset_i=1, the block SHALL force: state=IDLE, prio=0, counter=0, operand/id/result registers=0, resp_v_o=0, req_ready_o=0, busy_o=0.
REQ-026 Reset asserted mid-WAIT or mid-RESP SHALL abandon the transaction immediately; no response SHALL be emitted for it after reset is released.
REQ-027 The first arbitration after reset SHALL favour requester 0.

Structure
REQ-028 A shared package aes_ctrl_pkg SHALL hold the state enum and the width constants AES_BLOCK_W=128 and AES_KEY_W=256.
REQ-029 The block SHALL instantiate exactly one sub-module, aes_encryption (ports plaintext, initial_key, ciphertext).
REQ-030 The counter width SHALL be $clog2(SETTLE_CYCLES+1).

Verification
REQ-031 Single request on port 0 with plaintext 00112233445566778899aabbccddeeff and key 000102…1e1f -> resp_ciphertext_o=8ea2b7ca516745bfeafc49904b496089, resp_id_o=0, resp_v_o high exactly SETTLE_CYCLES+1 cycles after acceptance.
REQ-032 Both ports valid continuously, port 1 using the same vector -> grants alternate 0,1,0,1 and each response carries the correct id.
REQ-033 resp_ready_i held 0 for 10 cycles during RESP -> outputs stable, req_ready_o=00, busy_o=1; one handshake then returns the FSM to IDLE.
REQ-034 reset_i pulsed mid-WAIT -> all outputs reach reset values within the pulse, no spurious response follows, and the next grant goes to port 0.
REQ-035 SETTLE_CYCLES=1 with back-to-back requests -> latency 2 cycles and one idle cycle between a response handshake and the next acceptance.
